// File: rtl/csi_frame_monitor_pkg.sv
// Shared constants and types for the CSI frame geometry monitor.
// Default geometry matches a 1920x1080 sensor on a two-lane link.
package csi_frame_monitor_pkg;

    localparam int HSCREEN  = 1920;
    localparam int VSCREEN  = 1080;
    localparam int NUM_LANE = 2;

    localparam int EXP_WORDS_DEF = HSCREEN / NUM_LANE;
    localparam int EXP_LINES_DEF = VSCREEN;
    localparam int CNT_W_DEF     = 12;
    localparam int FPS_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } state_t;

endpackage

// File: rtl/csi_frame_monitor_edge_det.sv
// Registered level plus rise/fall strobes for one envelope signal.
// The first sample after reset only primes the history, so no edge is invented.
module csi_frame_monitor_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic q;
    logic q_d;
    logic armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= 1'b0;
            q_d   <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            q     <= d;
            q_d   <= armed ? q : d;
        end
    end

    assign level = q;
    assign rise  = q & ~q_d;
    assign fall  = ~q & q_d;

endmodule

// File: rtl/csi_frame_monitor.sv
// Measures words/line, lines/frame and frames/second of the CSI envelope
// and flags geometry deviations against the expected sensor mode.
module csi_frame_monitor
    import csi_frame_monitor_pkg::*;
#(
    parameter int EXP_WORDS = EXP_WORDS_DEF,
    parameter int EXP_LINES = EXP_LINES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FPS_W     = FPS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_frame,
    input  logic             in_line,
    input  logic             word_vld,
    input  logic             tick_1s,
    output logic [CNT_W-1:0] line_words,
    output logic [CNT_W-1:0] frame_lines,
    output logic [FPS_W-1:0] fps,
    output logic             frame_done,
    output logic             line_err,
    output logic             frame_err,
    output logic             trunc_err,
    output logic [1:0]       state_dbg
);

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [FPS_W-1:0] sat_fps(input logic [FPS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t state;
    state_t state_nxt;

    logic frame_lvl;
    logic frame_rise;
    logic frame_fall;
    logic line_lvl;
    logic line_rise;
    logic line_fall;
    logic wv;

    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] words_now;
    logic [CNT_W-1:0] lines_now;
    logic [FPS_W-1:0] win_cnt;

    logic frame_start;
    logic frame_close;
    logic line_start;
    logic line_close;

    csi_frame_monitor_edge_det u_frame_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (in_frame),
        .level (frame_lvl),
        .rise  (frame_rise),
        .fall  (frame_fall)
    );

    csi_frame_monitor_edge_det u_line_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (in_line),
        .level (line_lvl),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wv <= 1'b0;
        end else begin
            wv <= word_vld;
        end
    end

    assign frame_start = (state == ST_IDLE) && frame_rise;
    assign frame_close = (state != ST_IDLE) && frame_fall;
    assign line_start  = (state == ST_FRAME) && !frame_fall
                         && line_rise && frame_lvl;
    assign line_close  = (state == ST_LINE) && (line_fall || frame_fall);

    // A word in the closing cycle still belongs to the line being closed
    assign words_now = ((state == ST_LINE) && wv) ? sat_cnt(word_cnt)
                                                  : word_cnt;
    assign lines_now = line_close ? sat_cnt(line_cnt) : line_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (frame_start) state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (frame_fall)      state_nxt = ST_IDLE;
                else if (line_start) state_nxt = ST_LINE;
            end
            ST_LINE: begin
                if (frame_fall)     state_nxt = ST_IDLE;
                else if (line_fall) state_nxt = ST_FRAME;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        state_dbg = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt    <= '0;
            line_cnt    <= '0;
            line_words  <= '0;
            frame_lines <= '0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            frame_done <= frame_close;

            if (frame_start) begin
                line_cnt  <= '0;
                line_err  <= 1'b0;
                trunc_err <= 1'b0;
            end

            if (line_start) begin
                word_cnt <= wv ? CNT_W'(1) : '0;
            end else if (state == ST_LINE) begin
                word_cnt <= words_now;
            end

            if (line_close) begin
                line_words <= words_now;
                line_cnt   <= lines_now;
                if (words_now != CNT_W'(EXP_WORDS)) line_err <= 1'b1;
            end

            if (frame_close) begin
                frame_lines <= lines_now;
                frame_err   <= (lines_now != CNT_W'(EXP_LINES));
                if ((state == ST_LINE) && line_lvl) trunc_err <= 1'b1;
            end
        end
    end

    // A frame closing on the tick cycle is published, not carried over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            fps     <= '0;
        end else if (tick_1s) begin
            fps     <= frame_done ? sat_fps(win_cnt) : win_cnt;
            win_cnt <= '0;
        end else if (frame_done) begin
            win_cnt <= sat_fps(win_cnt);
        end
    end

endmodule
